memwb_stage: RTL and testbench
==============================

MEMWB_STAGE -- requirements
Module: memwb_stage

Interface
Parameters:
REQ-001 SHALL have parameter DW, default 32: data word width.
REQ-002 SHALL have parameter RW, default 5: register index width.
REQ-003 SHALL have parameter CW, default 16: retire counter width.
REQ-004 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer, 0 = single register with combinational in_ready.

Ports:
REQ-005 SHALL have one clock; reset is synchronous and active-high.
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
REQ-006 SHALL have these upstream ports:
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_alu  in  DW  ALU result
- in_dload  in  DW  memory load data
- in_npc  in  DW  PC+4
- in_wsel  in  RW  destination register
- in_regw  in  1  register write
- in_memtoreg  in  2  writeback source
- in_halt  in  1  halt instruction
- in_opcode  in  6  opcode
REQ-007 SHALL have these control and downstream ports:
- flush  in  1  kill all held entries
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback consumes
- out_wdat  out  DW  selected writeback data
- out_wsel  out  RW  destination register
- out_wen  out  1  out_valid and held regw
- out_halt  out  1  held halt flag, qualified by out_valid
- out_opcode  out  6  held opcode
- halted  out  1  sticky halt
- retired  out  CW  retired-instruction count

Function
REQ-008 SHALL accept an entry when in_valid and in_ready are both high; the entry SHALL appear at out_valid the next cycle (latency 1).
REQ-009 SHALL transfer an entry out when out_valid and out_ready are both high.
REQ-010 With SKID=1, in_ready SHALL be registered and equal to not skid_valid and not halted.
REQ-011 With SKID=1, an accepted entry SHALL go to the main register if it is empty or transferring this cycle, else to the skid register.
REQ-012 With SKID=1, a main-register transfer while skid_valid SHALL move the skid entry to main in the same edge, with skid_valid cleared.
REQ-013 With SKID=1, simultaneous accept, main transfer and skid_valid cannot occur, because in_ready is low.
REQ-014 With SKID=0, in_ready SHALL equal (not out_valid or out_ready) and not halted.
REQ-015 out_wdat SHALL be selected from in_memtoreg as held: 00 = alu, 01 = dload, 10 = npc, 11 = alu (reserved); the output is combinational from registered fields.
REQ-016 flush SHALL clear the main and skid valid bits at the edge and take priority over any accept in that cycle.
REQ-017 An entry transferred in the flush cycle SHALL count as retired.
REQ-018 halted SHALL set on transfer of an entry with halt=1 and SHALL stay set until RST; flush SHALL not clear it.
REQ-019 While halted, in_ready SHALL be 0, out_valid SHALL be 0 and held entries SHALL be discarded.
REQ-020 retired SHALL increment by 1 per transfer, including the halting entry, and SHALL wrap from 2^CW-1 to 0.
REQ-021 Held payload SHALL be stable while out_valid is high and out_ready is low.

Reset
REQ-022 RST SHALL clear main_valid, skid_valid, halted and retired, and drive all payload registers to 0.
REQ-023 After RST, out_valid, out_wen and out_halt SHALL be 0, and in_ready SHALL be 1 from the first post-reset cycle.
REQ-024 RST asserted mid-transfer SHALL win: no transfer SHALL be counted and no entry SHALL be retained.

Structure
REQ-025 word_t, regbits_t, opcode_t and a memtoreg_t enum (MTR_ALU, MTR_LOAD, MTR_NPC) SHALL live in cpu_types_pkg.
REQ-026 The valid/ready skid logic SHALL be a sub-module pipe_skid, parametrised on payload width and SKID; memwb_stage instantiates it with the packed payload and adds the writeback mux, halt and counter.

Verification
REQ-027 SHALL cover streaming: 8 back-to-back entries with out_ready=1 -> out_valid from cycle 1, in order, retired=8, in_ready never 0.
REQ-028 SHALL cover backpressure (SKID=1): out_ready=0 while 3 entries are offered -> 2 held, in_ready=0 from the cycle after the second accept; out_ready=1 -> drains in order, no loss or duplication.
REQ-029 SHALL cover the mux: alu=0x11, dload=0x22, npc=0x33 with memtoreg 00/01/10/11 -> out_wdat 0x11/0x22/0x33/0x11; regw=0 -> out_wen=0.
REQ-030 SHALL cover flush: 2 entries held, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, retired unchanged.
REQ-031 SHALL cover halt: a halt entry transferred -> halted=1 the next cycle, in_ready=0, later entries ignored; flush leaves halted=1; RST clears it.
REQ-032 SHALL cover wrap: CW=4, 17 transfers -> retired=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the writeback stage.
// Provides word/register-index/opcode typedefs, the writeback source enum and
// a decoder that folds the reserved memtoreg encoding onto the ALU source.
package cpu_types_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OPCODE_W  = 6;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [REG_IDX_W-1:0] regbits_t;
  typedef logic [OPCODE_W-1:0]  opcode_t;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_LOAD = 2'b01,
    MTR_NPC  = 2'b10
  } memtoreg_t;

  // Raw 2-bit field to enum; the unused 2'b11 code selects the ALU result.
  function automatic memtoreg_t decode_memtoreg(input logic [1:0] raw);
    memtoreg_t sel;
    case (raw)
      2'b01:   sel = MTR_LOAD;
      2'b10:   sel = MTR_NPC;
      default: sel = MTR_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pipe_skid.sv
// Generic valid/ready pipeline register with optional two-entry skid buffer.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear_i           drop all held entries at the next edge (beats any accept)
//   block_i           stage frozen: no accept, no output, held entries dropped
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload
// Skid=1: in_ready_o comes from flops (no combinational path from out_ready_i).
// Skid=0: single register, in_ready_o is combinational from out_ready_i.
module pipe_skid #(
  parameter int unsigned Width = 8,
  parameter bit          Skid  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             block_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             accept;
  logic             xfer;

  assign out_valid_o = main_valid_q & ~block_i;
  assign out_data_o  = main_q;
  assign xfer        = out_valid_o & out_ready_i;
  assign accept      = in_valid_i & in_ready_o;

  if (Skid) begin : g_skid
    logic ready_q;
    // Tracks "skid slot free" one cycle ahead so the output is a pure flop.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ready_q <= 1'b1;
      end else begin
        ready_q <= ~skid_valid_d;
      end
    end
    assign in_ready_o = ready_q & ~block_i;
  end else begin : g_single
    assign in_ready_o = (~main_valid_q | out_ready_i) & ~block_i;
  end

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (Skid) begin
      if (xfer) begin
        if (skid_valid_q) begin
          // in_ready was low, so no accept can collide with this refill.
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = in_data_i;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (!main_valid_q) begin
          main_d       = in_data_i;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = in_data_i;
          skid_valid_d = 1'b1;
        end
      end
    end else begin
      if (accept) begin
        main_d       = in_data_i;
        main_valid_d = 1'b1;
      end else if (xfer) begin
        main_valid_d = 1'b0;
      end
    end
    if (clear_i || block_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage: buffers memory-stage results, selects writeback data,
// tracks a sticky halt and counts retired instructions.
// Ports:
//   CLK, RST                clock, synchronous active-high reset
//   in_valid/in_ready       upstream handshake
//   in_alu/in_dload/in_npc  candidate writeback words
//   in_wsel/in_regw         destination register and write enable
//   in_memtoreg             writeback source select (00 alu, 01 load, 10 npc, 11 alu)
//   in_halt/in_opcode       halt flag and opcode carried to writeback
//   flush                   discard all held entries
//   out_valid/out_ready     downstream handshake
//   out_wdat/out_wsel/out_wen/out_halt/out_opcode  writeback view of held entry
//   halted                  sticky, set when a halt entry retires
//   retired                 wrapping count of retired entries
module memwb_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned RW   = 5,
  parameter int unsigned CW   = 16,
  parameter int unsigned SKID = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_dload,
  input  logic [DW-1:0] in_npc,
  input  logic [RW-1:0] in_wsel,
  input  logic          in_regw,
  input  logic [1:0]    in_memtoreg,
  input  logic          in_halt,
  input  opcode_t       in_opcode,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_wdat,
  output logic [RW-1:0] out_wsel,
  output logic          out_wen,
  output logic          out_halt,
  output opcode_t       out_opcode,
  output logic          halted,
  output logic [CW-1:0] retired
);

  localparam int unsigned PW = 3 * DW + RW + 1 + 2 + 1 + OPCODE_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] held_payload;

  logic [DW-1:0] h_alu, h_dload, h_npc;
  logic [RW-1:0] h_wsel;
  logic          h_regw;
  logic [1:0]    h_mtr;
  logic          h_halt;
  opcode_t       h_opcode;

  logic          xfer;
  logic          halt_xfer;
  logic          halted_q, halted_d;
  logic [CW-1:0] retired_q, retired_d;

  assign in_payload = {in_alu, in_dload, in_npc, in_wsel, in_regw, in_memtoreg, in_halt,
                       in_opcode};
  assign {h_alu, h_dload, h_npc, h_wsel, h_regw, h_mtr, h_halt, h_opcode} = held_payload;

  pipe_skid #(
    .Width (PW),
    .Skid  (SKID != 0)
  ) u_pipe (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clear_i     (flush | halt_xfer),
    .block_i     (halted_q),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_payload),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (held_payload)
  );

  assign xfer      = out_valid & out_ready;
  // A retiring halt also kills anything queued behind it.
  assign halt_xfer = xfer & h_halt;

  always_comb begin
    case (decode_memtoreg(h_mtr))
      MTR_LOAD: out_wdat = h_dload;
      MTR_NPC:  out_wdat = h_npc;
      default:  out_wdat = h_alu;
    endcase
  end

  assign out_wsel   = h_wsel;
  assign out_wen    = out_valid & h_regw;
  assign out_halt   = out_valid & h_halt;
  assign out_opcode = h_opcode;

  always_comb begin
    halted_d  = halted_q | halt_xfer;
    retired_d = retired_q;
    if (xfer) begin
      retired_d = retired_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] dload;
    logic [31:0] npc;
    logic [4:0]  wsel;
    logic        regw;
    logic [1:0]  mtr;
    logic        halt;
    logic [5:0]  opc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_alu, in_dload, in_npc;
  logic [4:0]  in_wsel;
  logic        in_regw, in_halt;
  logic [1:0]  in_memtoreg;
  logic [5:0]  in_opcode;

  // Default instance (SKID=1, CW=16)
  logic        in_ready, out_valid, out_wen, out_halt, halted;
  logic [31:0] out_wdat;
  logic [4:0]  out_wsel;
  logic [5:0]  out_opcode;
  logic [15:0] retired;

  // Second instance (SKID=0, CW=4)
  logic        in_ready_w, out_valid_w, out_wen_w, out_halt_w, halted_w;
  logic [31:0] out_wdat_w;
  logic [4:0]  out_wsel_w;
  logic [5:0]  out_opcode_w;
  logic [3:0]  retired_w;

  int vectors = 0;
  int miscompares = 0;

  ent_t        mq [2][$];
  bit          mh [2];
  int unsigned mret [2];

  always #5 clk = ~clk;

  memwb_stage dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu),
    .in_dload(in_dload), .in_npc(in_npc), .in_wsel(in_wsel), .in_regw(in_regw),
    .in_memtoreg(in_memtoreg), .in_halt(in_halt), .in_opcode(in_opcode), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdat(out_wdat), .out_wsel(out_wsel),
    .out_wen(out_wen), .out_halt(out_halt), .out_opcode(out_opcode), .halted(halted),
    .retired(retired)
  );

  memwb_stage #(.DW(32), .RW(5), .CW(4), .SKID(0)) dut_w (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_alu(in_alu),
    .in_dload(in_dload), .in_npc(in_npc), .in_wsel(in_wsel), .in_regw(in_regw),
    .in_memtoreg(in_memtoreg), .in_halt(in_halt), .in_opcode(in_opcode), .flush(flush),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_wdat(out_wdat_w),
    .out_wsel(out_wsel_w), .out_wen(out_wen_w), .out_halt(out_halt_w),
    .out_opcode(out_opcode_w), .halted(halted_w), .retired(retired_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ent_t e);
    in_alu      = e.alu;
    in_dload    = e.dload;
    in_npc      = e.npc;
    in_wsel     = e.wsel;
    in_regw     = e.regw;
    in_memtoreg = e.mtr;
    in_halt     = e.halt;
    in_opcode   = e.opc;
  endtask

  function automatic ent_t cur_entry();
    ent_t e;
    e.alu = in_alu; e.dload = in_dload; e.npc = in_npc; e.wsel = in_wsel;
    e.regw = in_regw; e.mtr = in_memtoreg; e.halt = in_halt; e.opc = in_opcode;
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] alu, input logic [1:0] mtr,
                              input logic regw, input logic halt);
    ent_t e;
    e = '0;
    e.alu = alu; e.dload = alu ^ 32'h5555_0000; e.npc = alu + 32'd4;
    e.mtr = mtr; e.regw = regw; e.halt = halt; e.wsel = alu[4:0]; e.opc = alu[5:0];
    return e;
  endfunction

  // Writeback value chosen by the source field; 11 falls back to the ALU word.
  function automatic logic [31:0] m_wdat(input ent_t e);
    if (e.mtr == 2'd1) return e.dload;
    if (e.mtr == 2'd2) return e.npc;
    return e.alu;
  endfunction

  // Instance 0 holds up to two entries and can accept whenever it has room;
  // instance 1 holds one and can accept when empty or emptying this cycle.
  function automatic bit m_ready(input int d);
    if (mh[d]) return 1'b0;
    if (d == 0) return mq[d].size() < 2;
    return (mq[d].size() == 0) || out_ready;
  endfunction

  task automatic model_step();
    bit acc, xf, killed;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mq[d].delete(); mh[d] = 1'b0; mret[d] = 0;
      end else begin
        acc    = in_valid && m_ready(d);
        xf     = (mq[d].size() > 0) && out_ready;
        killed = 1'b0;
        if (xf) begin
          mret[d]++;
          if (mq[d][0].halt) begin
            mh[d] = 1'b1; killed = 1'b1;
          end
          void'(mq[d].pop_front());
        end
        if (killed || flush) mq[d].delete();
        else if (acc) mq[d].push_back(cur_entry());
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive('0);
    repeat (2) tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mq[d].delete(); mh[d] = 1'b0; mret[d] = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors += 8;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out_wen !== 1'b0) begin miscompares++; $display("FAIL rst_out_wen got %b want 0", out_wen); end
    if (out_halt !== 1'b0) begin miscompares++; $display("FAIL rst_out_halt got %b want 0", out_halt); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b want 0", halted); end
    if (retired !== 16'd0) begin miscompares++; $display("FAIL rst_retired got %0d want 0", retired); end
    if (in_ready_w !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready_w got %b want 1", in_ready_w); end
    if (retired_w !== 4'd0) begin miscompares++; $display("FAIL rst_retired_w got %0d want 0", retired_w); end
    // Reset arriving while a transfer is offered must win.
    tick();
    out_ready = 1'b1; in_valid = 1'b1; drive(mk(32'h77, 2'd0, 1'b1, 1'b0));
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (retired !== 16'd0) begin miscompares++; $display("FAIL rst_mid_retired got %0d want 0", retired); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 8);
      drive(mk(32'h100 + i, 2'd0, 1'b1, 1'b0));
      @(negedge clk);
      vectors += 2;
      if (i < 8 && in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
      if (out_valid !== (i > 0)) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want %b", i, out_valid, i > 0); end
      if (i > 0) begin
        vectors++;
        if (out_wdat !== 32'h100 + i - 1) begin miscompares++; $display("FAIL stream_wdat[%0d] got %h want %h", i, out_wdat, 32'h100 + i - 1); end
      end
      tick();
    end
    @(negedge clk);
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drained got %b want 0", out_valid); end
    if (retired !== 16'd8) begin miscompares++; $display("FAIL stream_retired got %0d want 8", retired); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [31:0] want [3];
    bit pending;
    want = '{32'hA0, 32'hB0, 32'hC0};
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(mk(want[(i < 2) ? i : 2], 2'd0, 1'b1, 1'b0));
      @(negedge clk);
      vectors++;
      if (in_ready !== (i < 2)) begin miscompares++; $display("FAIL bp_ready[%0d] got %b want %b", i, in_ready, i < 2); end
      if (i > 0) begin
        vectors++;
        if (out_wdat !== want[0]) begin miscompares++; $display("FAIL bp_hold[%0d] got %h want %h", i, out_wdat, want[0]); end
      end
      tick();
    end
    out_ready = 1'b1;
    pending = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = pending;
      @(negedge clk);
      if (out_valid) got.push_back(out_wdat);
      if (in_valid && in_ready) pending = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    vectors += 3;
    if (pending) begin miscompares++; $display("FAIL bp_third_accept got pending want accepted"); end
    if (got.size() != 3) begin miscompares++; $display("FAIL bp_count got %0d want 3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got[i] !== want[i]) begin miscompares++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], want[i]); end
      end
    end
    if (retired !== 16'd3) begin miscompares++; $display("FAIL bp_retired got %0d want 3", retired); end
  endtask

  task automatic test_mux();
    ent_t e;
    logic [31:0] exp_w [4];
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h11};
    do_reset();
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      e = '0;
      e.alu = 32'h11; e.dload = 32'h22; e.npc = 32'h33; e.mtr = 2'(m);
      e.regw = (m != 3); e.opc = 6'(m + 8);
      in_valid = 1'b1; drive(e);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      vectors += 4;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mux_valid[%0d] got %b want 1", m, out_valid); end
      if (out_wdat !== exp_w[m]) begin miscompares++; $display("FAIL mux_wdat[%0d] got %h want %h", m, out_wdat, exp_w[m]); end
      if (out_wen !== (m != 3)) begin miscompares++; $display("FAIL mux_wen[%0d] got %b want %b", m, out_wen, m != 3); end
      if (out_opcode !== 6'(m + 8)) begin miscompares++; $display("FAIL mux_opcode[%0d] got %0d want %0d", m, out_opcode, m + 8); end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(mk(32'h1, 2'd0, 1'b1, 1'b0)); tick();
    drive(mk(32'h2, 2'd0, 1'b1, 1'b0)); tick();
    drive(mk(32'h3, 2'd0, 1'b1, 1'b0)); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", in_ready); end
    if (retired !== 16'd0) begin miscompares++; $display("FAIL flush_retired got %0d want 0", retired); end
    // An entry leaving on the flush edge still counts.
    in_valid = 1'b1; drive(mk(32'h4, 2'd0, 1'b1, 1'b0));
    tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (retired !== 16'd1) begin miscompares++; $display("FAIL flush_xfer_retired got %0d want 1", retired); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_xfer_valid got %b want 0", out_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(mk(32'hAA, 2'd0, 1'b1, 1'b1));
    tick();
    drive(mk(32'hBB, 2'd0, 1'b1, 1'b0));
    @(negedge clk);
    vectors += 2;
    if (out_halt !== 1'b1) begin miscompares++; $display("FAIL halt_out_halt got %b want 1", out_halt); end
    if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early got %b want 0", halted); end
    tick();
    @(negedge clk);
    vectors += 3;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_set got %b want 1", halted); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL halt_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL halt_valid got %b want 0", out_valid); end
    repeat (3) tick();
    @(negedge clk);
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL halt_ignore_valid got %b want 0", out_valid); end
    if (retired !== 16'd1) begin miscompares++; $display("FAIL halt_retired got %0d want 1", retired); end
    flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_after_flush got %b want 1", halted); end
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_rst got %b want 0", halted); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL halt_rst_ready got %b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(mk(32'h200 + i, 2'd0, 1'b1, 1'b0));
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    vectors += 2;
    if (retired_w !== 4'd1) begin miscompares++; $display("FAIL wrap_retired_w got %0d want 1", retired_w); end
    if (retired !== 16'd17) begin miscompares++; $display("FAIL wrap_retired got %0d want 17", retired); end
  endtask

  task automatic test_random();
    ent_t e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0) || (mh[0] && mh[1]);
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 29) == 0;
      e.alu = $urandom; e.dload = $urandom; e.npc = $urandom;
      e.wsel = 5'($urandom); e.regw = 1'($urandom); e.mtr = 2'($urandom);
      e.opc = 6'($urandom); e.halt = ($urandom_range(0, 39) == 0);
      drive(e);
      @(negedge clk);
      if (!rst) begin
        vectors += 6;
        if (out_valid !== (mq[0].size() > 0)) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b want %b", c, out_valid, mq[0].size() > 0); end
        if (in_ready !== m_ready(0)) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b want %b", c, in_ready, m_ready(0)); end
        if (halted !== mh[0]) begin miscompares++; $display("FAIL rnd_halted[%0d] got %b want %b", c, halted, mh[0]); end
        if (retired !== 16'(mret[0])) begin miscompares++; $display("FAIL rnd_retired[%0d] got %0d want %0d", c, retired, 16'(mret[0])); end
        if (out_valid_w !== (mq[1].size() > 0)) begin miscompares++; $display("FAIL rnd_valid_w[%0d] got %b want %b", c, out_valid_w, mq[1].size() > 0); end
        if (retired_w !== 4'(mret[1])) begin miscompares++; $display("FAIL rnd_retired_w[%0d] got %0d want %0d", c, retired_w, 4'(mret[1])); end
        vectors++;
        if (in_ready_w !== m_ready(1)) begin miscompares++; $display("FAIL rnd_ready_w[%0d] got %b want %b", c, in_ready_w, m_ready(1)); end
        if (mq[0].size() > 0) begin
          vectors += 4;
          if (out_wdat !== m_wdat(mq[0][0])) begin miscompares++; $display("FAIL rnd_wdat[%0d] got %h want %h", c, out_wdat, m_wdat(mq[0][0])); end
          if (out_wen !== mq[0][0].regw) begin miscompares++; $display("FAIL rnd_wen[%0d] got %b want %b", c, out_wen, mq[0][0].regw); end
          if (out_halt !== mq[0][0].halt) begin miscompares++; $display("FAIL rnd_halt[%0d] got %b want %b", c, out_halt, mq[0][0].halt); end
          if (out_wsel !== mq[0][0].wsel) begin miscompares++; $display("FAIL rnd_wsel[%0d] got %0d want %0d", c, out_wsel, mq[0][0].wsel); end
        end
        if (mq[1].size() > 0) begin
          vectors += 2;
          if (out_wdat_w !== m_wdat(mq[1][0])) begin miscompares++; $display("FAIL rnd_wdat_w[%0d] got %h want %h", c, out_wdat_w, m_wdat(mq[1][0])); end
          if (out_opcode_w !== mq[1][0].opc) begin miscompares++; $display("FAIL rnd_opcode_w[%0d] got %0d want %0d", c, out_opcode_w, mq[1][0].opc); end
        end
      end
      model_step();
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_mux();
    test_flush();
    test_halt();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
